// File: rtl/wb_uart_pkg.sv
// Shared UART definitions: parity encodings, STATUS bit layout, receiver
// FSM states and the receive latency used by benches and system models.
package wb_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // STATUS register bit positions
    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVR    = 2;
    localparam int ST_FERR   = 3;
    localparam int ST_PERR   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    // Clocks from the first clock edge after the start-bit falling edge of
    // the RX pin (the edge that samples it) to the edge that pushes the
    // FIFO; o_irq is high in the cycle following the push.
    function automatic int RX_LATENCY(input int ticks, input int dbits,
                                      input int parity, input int stops);
        return 2 + ticks * (1 + dbits + ((parity != PAR_NONE) ? 1 : 0) + stops - 1)
               + ticks / 2 - 1 + 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered occupancy count. A pop on a full FIFO
// frees the slot for a push in the same cycle; a pop on empty is ignored.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Next occupancy: unchanged when push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_uart_rx_fifo.sv
// UART receiver with receive FIFO behind a Wishbone B4 pipelined slave.
// Address 0 pops received bytes, address 1 reads and clears STATUS.
// Bus handshake: every strobe is accepted (stall tied low); the ack is
// registered and appears exactly one cycle after the accept, with data.
module wb_uart_rx_fifo
    import wb_uart_pkg::*;
#(
    parameter int TICKS_PER_BAUD = 8,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst_n,
    input  logic       i_wb_stb,
    input  logic       i_wb_adr,
    output logic [7:0] o_wb_data,
    output logic       o_wb_stall,
    output logic       o_wb_ack,
    input  logic       i_uart_rx,
    output logic       o_irq,
    output rx_state_e  o_dbg_state
);
    localparam int CW = $clog2(TICKS_PER_BAUD);
    localparam logic [CW-1:0] MID_C       = CW'(TICKS_PER_BAUD / 2);
    localparam logic [CW-1:0] LAST_C      = CW'(TICKS_PER_BAUD - 1);
    localparam logic [2:0]    DATA_LAST_C = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST_C = 3'(STOP_BITS - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_bad_q, stop_bad_q;
    logic          mid, last_tick, exp_par;
    logic          stop_done, ferr_set, perr_set, frame_push, ovr_set;
    logic          fifo_full, fifo_empty, pop;
    logic [7:0]    fifo_rdata, status_w, rd_data_d;
    logic          status_rd;
    logic          ack_q, ovr_q, ferr_q, perr_q, ovr_d, ferr_d, perr_d;
    logic [7:0]    data_q;

    assign rx_s      = sync_q[1];
    assign mid       = (baud_cnt_q == MID_C);
    assign last_tick = (baud_cnt_q == LAST_C);
    // Unused upper data bits are zero, so they do not disturb the XOR
    assign exp_par   = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

    // Frame ends at the mid-sample of the final stop bit
    assign stop_done  = (state_q == S_STOP) && mid && (bit_cnt_q == STOP_LAST_C);
    assign ferr_set   = stop_done && (!rx_s || stop_bad_q);
    assign perr_set   = stop_done && par_bad_q;
    assign frame_push = stop_done && !ferr_set && !par_bad_q;
    assign pop        = i_wb_stb && !i_wb_adr && !fifo_empty;
    assign ovr_set    = frame_push && fifo_full && !pop;
    assign status_rd  = i_wb_stb && i_wb_adr;

    assign o_wb_stall  = 1'b0;
    assign o_wb_ack    = ack_q;
    assign o_wb_data   = data_q;
    assign o_irq       = !fifo_empty;
    assign o_dbg_state = state_q;

    // Two-flop synchroniser, idle-high after reset
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_uart_rx};
        end
    end

    // Receive FSM: mid-bit sampling, advance on counter wrap
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            baud_cnt_q <= last_tick ? '0 : baud_cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    baud_cnt_q <= '0;
                    if (!rx_s) begin
                        state_q    <= S_START;
                        baud_cnt_q <= CW'(1);
                        bit_cnt_q  <= '0;
                        shift_q    <= '0;
                        par_bad_q  <= 1'b0;
                        stop_bad_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (mid && rx_s) begin
                        state_q    <= S_IDLE;
                        baud_cnt_q <= '0;
                    end else if (last_tick) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mid) shift_q[bit_cnt_q] <= rx_s;
                    if (last_tick) begin
                        if (bit_cnt_q == DATA_LAST_C) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (mid) par_bad_q <= (rx_s != exp_par);
                    if (last_tick) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (stop_done) begin
                        state_q    <= S_IDLE;
                        baud_cnt_q <= '0;
                    end else begin
                        if (mid && !rx_s) stop_bad_q <= 1'b1;
                        if (last_tick) bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_wb_clk),
        .rst_ni  (i_wb_rst_n),
        .push_i  (frame_push),
        .wdata_i (shift_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Read mux and sticky flags; a set in the clearing cycle wins
    always_comb begin
        status_w            = '0;
        status_w[ST_NEMPTY] = !fifo_empty;
        status_w[ST_FULL]   = fifo_full;
        status_w[ST_OVR]    = ovr_q;
        status_w[ST_FERR]   = ferr_q;
        status_w[ST_PERR]   = perr_q;
        rd_data_d = '0;
        if (i_wb_stb) begin
            if (i_wb_adr)         rd_data_d = status_w;
            else if (!fifo_empty) rd_data_d = fifo_rdata;
        end
        ovr_d  = (ovr_q  && !status_rd) || ovr_set;
        ferr_d = (ferr_q && !status_rd) || ferr_set;
        perr_d = (perr_q && !status_rd) || perr_set;
    end

    // Bus response and flag registers
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            ack_q  <= 1'b0;
            data_q <= '0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            ack_q  <= i_wb_stb;
            data_q <= rd_data_d;
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
            perr_q <= perr_d;
        end
    end

endmodule

// File: doc/wb_uart_rx_fifo.md
# wb_uart_rx_fifo

Parametrised UART receiver with a Wishbone B4 pipelined slave port, receive FIFO and error reporting. Configurable data width, parity and stop bits, with false-start rejection and an input synchroniser. Received bytes are buffered so the bus master can drain them in bursts. The block sits between the board RX pin and the Wishbone interconnect, alongside the UART transmitter.

## Interface
- `TICKS_PER_BAUD`, 8: clock cycles per bit; minimum 4.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, minimum 2.

Ports:
- `i_wb_clk`, in, 1: the only clock.
- `i_wb_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_wb_stb`, in, 1: request strobe.
- `i_wb_adr`, in, 1: 0 = DATA (read pops the FIFO), 1 = STATUS.
- `o_wb_data`, out, 8: read data, valid while `o_wb_ack` is high.
- `o_wb_stall`, out, 1: always 0.
- `o_wb_ack`, out, 1: one-cycle acknowledge.
- `i_uart_rx`, in, 1: asynchronous serial input, idle high.
- `o_irq`, out, 1: high while the FIFO is non-empty.

## Operation
- **Input path:** `i_uart_rx` passes through a 2-FF synchroniser. All decisions use the synchronised value `rx_s`.
- **Bit counter:** `baud_cnt` is `$clog2(TICKS_PER_BAUD)` bits wide. It is always `< TICKS_PER_BAUD`.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rx_s == 0` -> START, `baud_cnt <= 1`.
  - In every non-IDLE state, `rx_s` is sampled when `baud_cnt == TICKS_PER_BAUD/2`.
  - START: a sample of 1 is a false start -> IDLE, nothing recorded.
  - At `baud_cnt == TICKS_PER_BAUD-1`: counter wraps to 0 and the state advances.
  - DATA: bits arrive LSB first, non-inverted, for `DATA_BITS` periods.
  - PARITY: present only if `PARITY != 0`.
  - STOP: `STOP_BITS` periods.
- **End of frame:** at the mid-sample of the final stop bit the frame completes and the FSM goes directly to IDLE, which gives half a bit of resync margin.
  - Any stop sample of 0 sets `ferr` and the frame is discarded.
  - A parity mismatch sets `perr` and the frame is discarded.
  - Otherwise the data is pushed into the FIFO, zero-extended to 8 bits.
- **FIFO push when full:** the new byte is dropped and `ovr` is set. If a pop is accepted in the same cycle, the push succeeds and `ovr` is not set.
- **DATA read:**
  - FIFO non-empty: returns the head entry and pops it in the accept cycle.
  - FIFO empty: returns `0x00`; no pop and no underflow side effect.
- **STATUS read:** returns `{3'b0, perr, ferr, ovr, full, !empty}`, bit 0 being `!empty`.
  - The read clears `ovr`, `ferr` and `perr`.
  - If a flag sets in the same cycle as the clearing read, the flag stays set.
- **`o_irq`:** equals `!empty` from the FIFO count register. No extra latency.

## Timing
- **Reset values:** `o_wb_ack=0`, `o_wb_data=0`, `o_wb_stall=0`, `o_irq=0`. FSM in IDLE, FIFO empty, flags 0, synchroniser flops 1.
- **Reset mid-frame:** reset aborts the frame and empties the FIFO. After release, the first received frame is a clean frame.
- **Bus:** every strobe is accepted, since stall is 0.
  - `o_wb_ack` rises exactly 1 cycle after the accept cycle, with `o_wb_data`.
  - Back-to-back strobes produce back-to-back acks.
  - Back-to-back DATA reads pop consecutive entries.
- **Rx latency:** from the `i_uart_rx` falling edge of the start bit to the FIFO push (`o_irq` high the next cycle), in clocks:
  - 2 (synchroniser) + `TICKS_PER_BAUD*(1+DATA_BITS+(PARITY!=0)+STOP_BITS-1)` + `TICKS_PER_BAUD/2` - 1 + 1.
  - This expression is ±1 by definition; the bench checks it exactly against the RTL constant `RX_LATENCY` exported from the package.
- **Back-to-back frames:** a new start bit may begin immediately after the final stop bit and must be received.

## Structure
- Package `wb_uart_pkg`:
  - PARITY encodings `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
  - STATUS bit indices.
  - FSM state enum.
  - `RX_LATENCY` function of the parameters.
  - Shared with the TX block.
- Sub-module `fifo_sync`: `WIDTH`, `DEPTH`, push/pop/full/empty. Simultaneous push+pop is legal when full or empty. Single-cycle registered count.

## Test plan
- **Plain frame:** defaults, frame `0xA5` -> DATA read returns `0xA5`, `o_irq` drops the cycle after the pop, STATUS reads `0x00`.
- **Glitch rejection:** a 2-cycle low glitch on `i_uart_rx` -> no push, FSM back in IDLE, flags 0.
- **Even parity:** `PARITY=2`, `DATA_BITS=7`, send `0x41` with a wrong parity bit -> no push, STATUS `0x10`; a second STATUS read returns `0x00`.
- **Framing error:** stop bit held low on frame `0x3C` -> STATUS `0x08`, FIFO empty.
- **Overflow:** `FIFO_DEPTH=4`, 5 frames `0x01..0x05` with no reads -> STATUS `0x07`; four DATA reads return `0x01..0x04`; a fifth read returns `0x00`.
- **Reset mid-frame:** `i_wb_rst_n` asserted during data bit 3 with one entry queued -> all outputs at reset values; the next frame `0x5A` reads back correctly.
